// File: rtl/issue_queue_pkg.sv
// rtl/issue_queue_pkg.sv - shared types, per-class defaults and helpers for the age-ordered issue queue
package issue_queue_pkg;

  localparam int IQ_TAG_W             = 6;
  localparam int IQ_PAYLOAD_W         = 128;
  localparam int IQ_DEPTH_DEFAULT     = 8;
  localparam int IQ_WRITE_NUM_DEFAULT = 2;
  localparam int IQ_WAKE_NUM_DEFAULT  = 4;

  typedef enum logic [1:0] {
    IQ_CLASS_ALU,
    IQ_CLASS_MEM,
    IQ_CLASS_BRANCH,
    IQ_CLASS_MULT
  } iq_class_e;

  typedef struct packed {
    logic [IQ_TAG_W-1:0] tag;
    logic                rdy;
  } iq_src_t;

  typedef struct packed {
    logic                    valid;
    logic [IQ_TAG_W-1:0]     dst;
    iq_src_t                 src1;
    iq_src_t                 src2;
    logic [IQ_PAYLOAD_W-1:0] payload;
  } iq_entry_t;

  typedef struct packed {
    logic                valid;
    logic [IQ_TAG_W-1:0] tag;
  } wake_req_t;

  function automatic int iq_class_depth(input iq_class_e c);
    case (c)
      IQ_CLASS_ALU:    return 16;
      IQ_CLASS_MEM:    return 12;
      IQ_CLASS_BRANCH: return 8;
      default:         return IQ_DEPTH_DEFAULT;
    endcase
  endfunction

  function automatic int iq_class_write_num(input iq_class_e c);
    case (c)
      IQ_CLASS_ALU: return 2;
      IQ_CLASS_MEM: return 2;
      default:      return 1;
    endcase
  endfunction

  function automatic int unsigned iq_popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/age_issue_select.sv
// rtl/age_issue_select.sv - priority encoder returning the lowest-index ready slot
module age_issue_select #(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] ready_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  // Scan from the top so the lowest (oldest) ready slot is the last writer.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready_i[i]) begin
        idx_o   = IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/age_issue_queue.sv
// rtl/age_issue_queue.sv - age-ordered compacting issue queue, oldest ready entry issues first
// ISSUE_QUEUE_WRITE_WAKE_EN: same-cycle wakeups also set source readiness of entries being written.
module age_issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH     = IQ_DEPTH_DEFAULT,
  parameter int WRITE_NUM = IQ_WRITE_NUM_DEFAULT,
  parameter int WAKE_NUM  = IQ_WAKE_NUM_DEFAULT,
  parameter int TAG_W     = IQ_TAG_W,
  parameter int PAYLOAD_W = IQ_PAYLOAD_W
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 flush,
  input  logic [WRITE_NUM-1:0]                 in_valid,
  input  logic [WRITE_NUM-1:0][TAG_W-1:0]      in_dst,
  input  logic [WRITE_NUM-1:0][TAG_W-1:0]      in_src1_tag,
  input  logic [WRITE_NUM-1:0][TAG_W-1:0]      in_src2_tag,
  input  logic [WRITE_NUM-1:0]                 in_src1_rdy,
  input  logic [WRITE_NUM-1:0]                 in_src2_rdy,
  input  logic [WRITE_NUM-1:0][PAYLOAD_W-1:0]  in_payload,
  output logic                                 in_ready,
  input  logic [WAKE_NUM-1:0]                  wake_valid,
  input  logic [WAKE_NUM-1:0][TAG_W-1:0]       wake_tag,
  output logic                                 issue_valid,
  input  logic                                 issue_ready,
  output logic [TAG_W-1:0]                     issue_dst,
  output logic [TAG_W-1:0]                     issue_src1_tag,
  output logic [TAG_W-1:0]                     issue_src2_tag,
  output logic [PAYLOAD_W-1:0]                 issue_payload,
  output logic [$clog2(DEPTH+1)-1:0]           count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             rdy;
  } src_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W-1:0]     dst;
    src_t                 src1;
    src_t                 src2;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t           entries_q [DEPTH];
  entry_t           entries_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;

  logic [DEPTH-1:0] slot_ready;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic             do_issue;
  logic             do_write;

  int               wr_base;
  int               wr_off;
  logic [IDX_W-1:0] wr_slot;
  entry_t           new_e;

  function automatic logic wake_hit(
    input logic [WAKE_NUM-1:0]            wv,
    input logic [WAKE_NUM-1:0][TAG_W-1:0] wt,
    input logic [TAG_W-1:0]               tag
  );
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WAKE_NUM; k++) begin
      hit |= wv[k] && (wt[k] == tag);
    end
    return hit;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_ready[i] = entries_q[i].valid & entries_q[i].src1.rdy & entries_q[i].src2.rdy;
    end
  end

  age_issue_select #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_select (
    .ready_i (slot_ready),
    .idx_o   (sel_idx),
    .found_o (sel_found)
  );

  assign issue_valid    = sel_found & ~flush;
  assign issue_dst      = sel_found ? entries_q[sel_idx].dst      : '0;
  assign issue_src1_tag = sel_found ? entries_q[sel_idx].src1.tag : '0;
  assign issue_src2_tag = sel_found ? entries_q[sel_idx].src2.tag : '0;
  assign issue_payload  = sel_found ? entries_q[sel_idx].payload  : '0;

  // in_ready looks only at the registered count so dispatch never waits on issue.
  assign in_ready = (count_q <= CNT_W'(DEPTH - WRITE_NUM));
  assign do_issue = issue_valid & issue_ready;
  assign do_write = in_ready & (|in_valid) & ~flush;
  assign count    = count_q;

  always_comb begin
    entries_d = entries_q;
    new_e     = '0;
    wr_slot   = '0;
    wr_off    = 0;
    wr_base   = int'(count_q) - (do_issue ? 1 : 0);

    // Removal first: everything above the issued slot moves down one.
    if (do_issue) begin
      for (int j = 0; j < DEPTH - 1; j++) begin
        if (j >= int'(sel_idx)) begin
          entries_d[j] = entries_q[j + 1];
        end
      end
      entries_d[DEPTH-1] = '0;
    end

    // Wakeup lands on the entry's post-shift position.
    for (int j = 0; j < DEPTH; j++) begin
      if (entries_d[j].valid) begin
        if (wake_hit(wake_valid, wake_tag, entries_d[j].src1.tag)) entries_d[j].src1.rdy = 1'b1;
        if (wake_hit(wake_valid, wake_tag, entries_d[j].src2.tag)) entries_d[j].src2.rdy = 1'b1;
      end
    end

    if (do_write) begin
      for (int l = 0; l < WRITE_NUM; l++) begin
        if (in_valid[l]) begin
          new_e.valid    = 1'b1;
          new_e.dst      = in_dst[l];
          new_e.src1.tag = in_src1_tag[l];
          new_e.src2.tag = in_src2_tag[l];
          new_e.payload  = in_payload[l];
`ifdef ISSUE_QUEUE_WRITE_WAKE_EN
          new_e.src1.rdy = in_src1_rdy[l] | wake_hit(wake_valid, wake_tag, in_src1_tag[l]);
          new_e.src2.rdy = in_src2_rdy[l] | wake_hit(wake_valid, wake_tag, in_src2_tag[l]);
`else
          new_e.src1.rdy = in_src1_rdy[l];
          new_e.src2.rdy = in_src2_rdy[l];
`endif
          wr_slot            = IDX_W'(wr_base + wr_off);
          entries_d[wr_slot] = new_e;
          wr_off             = wr_off + 1;
        end
      end
    end

    count_d = CNT_W'(wr_base + wr_off);

    if (flush) begin
      for (int j = 0; j < DEPTH; j++) begin
        entries_d[j] = '0;
      end
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

endmodule

// File: doc/age_issue_queue.md
# age_issue_queue

Parametrised, age-ordered issue queue for the out-of-order backend. It replaces the fixed per-class queues (ALU/MEM/BRANCH/MULT) with one configurable block instantiated per functional-unit class. It accepts up to WRITE_NUM renamed micro-ops per cycle from dispatch and tracks source readiness through WAKE_NUM wakeup broadcasts. Each cycle it issues the oldest fully-ready entry to its functional unit.

## Interface
- DEPTH, 8: number of entries (≥ WRITE_NUM, ≥ 2)
- WRITE_NUM, 2: dispatch lanes per cycle
- WAKE_NUM, 4: wakeup broadcast ports
- TAG_W, 6: physical-register tag width
- PAYLOAD_W, 128: opaque payload width (control, imm, pcplus8, op, exception)
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  discard all entries (mispredict/exception)
- in_valid  in  WRITE_NUM  per-lane write request
- in_dst  in  WRITE_NUM×TAG_W  destination tag
- in_src1_tag, in_src2_tag  in  WRITE_NUM×TAG_W  source tags
- in_src1_rdy, in_src2_rdy  in  WRITE_NUM  source already available
- in_payload  in  WRITE_NUM×PAYLOAD_W  payload
- in_ready  out  1  free slots ≥ WRITE_NUM
- wake_valid  in  WAKE_NUM  wakeup strobe
- wake_tag  in  WAKE_NUM×TAG_W  produced tag
- issue_valid  out  1  oldest ready entry presented
- issue_ready  in  1  FU accepts
- issue_dst, issue_src1_tag, issue_src2_tag  out  TAG_W  selected entry fields
- issue_payload  out  PAYLOAD_W  selected payload
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Compacting queue: slot 0 oldest; occupied slots contiguous from 0; count = number of valid slots.
- Write: accepted only when in_ready; all valid lanes written together (all-or-nothing), appended after the last occupied slot in lane order, lane 0 oldest; sparse in_valid compacted (lanes {0,2} → slots count, count+1). in_valid with in_ready=0 is ignored, not buffered.
- Wake: each cycle, every occupied entry sets srcN_rdy if any wake_valid[k] && wake_tag[k]==srcN_tag. Multiple matches and duplicate tags are harmless.
- Select: lowest-index entry with both rdy bits set; issue_valid=1 if one exists and flush=0. Outputs are combinational from registered state.
- Issue: on issue_valid && issue_ready the selected entry is removed and younger entries shift down one slot.
- Same cycle issue + write: removal applies first, new entries append after the compacted tail; count_next = count − issued + written.
- Wake in the same cycle as shift: the rdy update applies to the entry at its new position.
- flush: count_next=0, all valid bits cleared; it dominates write and issue, and issue_valid is forced 0 that cycle.
- Reset: all valid bits 0, count=0, issue_valid=0, in_ready=1, issue_* fields 0.

## Timing
- Write in cycle N → eligible to issue in N+1 if its sources are ready.
- Wake in cycle N → entry issuable in N+1 (rdy is registered).
- in_ready depends only on registered count, not on same-cycle issue.
- Throughput: 1 issue/cycle, WRITE_NUM writes/cycle.
- Reset may assert mid-operation; all state clears asynchronously.

## Configuration
- ISSUE_QUEUE_WRITE_WAKE_EN defined: wake ports are also compared against incoming in_srcN_tag in the write cycle; a match sets rdy on write, which closes the dispatch/wakeup race.
- Undefined: in_srcN_rdy is captured as given. Dispatch guarantees it already reflects wakeups of the current cycle.

## Structure
- Shared package issue_queue_pkg holds: entry typedef (valid, dst, src1/src2 {tag, rdy}, payload), wake_req_t, and the per-class DEPTH/WRITE_NUM defaults.
- One sub-module: age_issue_select, a priority-encode of the lowest-index ready slot returning index and found.

## Test plan
- Reset, write lane0 {dst=5, src rdy=1,1}, issue_ready=1 → issue_valid at cycle+1 with issue_dst=5; count 1→0.
- Write src1_tag=9 rdy=0, wake_tag[2]=9 two cycles later → issue_valid exactly one cycle after the wake, not before.
- DEPTH=8, fill to 7 → in_ready=0; issue one → count 6, in_ready=1 next cycle.
- Entries A (slot 0, not ready) and B (slot 1, ready) → B issues; A shifts to slot 0, and a later wake of A issues it.
- Issue plus 2 writes in the same cycle at count=5 → count=6 with age order preserved; flush together with writes → count=0, issue_valid=0.
- Write with src tag 12 while wake_tag=12 in the same cycle → issues next cycle with ISSUE_QUEUE_WRITE_WAKE_EN defined; stays blocked without it.
